// File: rtl/err_monitor.sv
// err_monitor: folds per-stage error flags, a no-progress watchdog and an
// after-halt activity check into one sticky err flag, and records the first
// fault with a cause code.
// Build option: define ERR_MON_WDOG_EN to include the commit watchdog
// (cause 2). Without it, wdog_cnt reads 0 and the design has no counter flops.
module err_monitor #(
  parameter int NUM_SRC     = 4,
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_err,
  input  logic               commit,
  input  logic               halt,
  output logic               err,
  output logic [1:0]         err_cause,
  output logic [NUM_SRC-1:0] err_src,
  output logic [CNT_W-1:0]   wdog_cnt
);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_SRC   = 2'd1;
  localparam logic [1:0] CAUSE_WDOG  = 2'd2;
  localparam logic [1:0] CAUSE_HALT  = 2'd3;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               err_d;
  logic [1:0]         cause_d;
  logic [NUM_SRC-1:0] src_d;

`ifdef ERR_MON_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign wdog_cnt = cnt_q;
`else
  assign wdog_cnt = '0;
`endif

  // Next-state and next-record logic; every register holds unless a branch moves it.
  always_comb begin
    state_d = state_q;
    err_d   = err;
    cause_d = err_cause;
    src_d   = err_src;
`ifdef ERR_MON_WDOG_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_RUN: begin
        if (|src_err) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
          cause_d = CAUSE_SRC;
          src_d   = src_err;
        end else if (halt) begin
          // a commit alongside halt is legal; counter just freezes
          state_d = S_HALTED;
        end
`ifdef ERR_MON_WDOG_EN
        // commit beats the timeout when both land on the same cycle
        else if (commit) begin
          cnt_d = '0;
        end else if (cnt_q == WDOG_LAST) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
          cause_d = CAUSE_WDOG;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      S_HALTED: begin
        if (|src_err) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
          cause_d = CAUSE_SRC;
          src_d   = src_err;
        end else if (commit) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
          cause_d = CAUSE_HALT;
        end
      end
      S_FAULT: begin
        // first fault is sticky until reset
      end
      default: begin
        // corrupted state register: fail loudly with no cause
        state_d = S_FAULT;
        err_d   = 1'b1;
        cause_d = CAUSE_NONE;
        src_d   = '0;
      end
    endcase
  end

  // State and fault record registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      err       <= 1'b0;
      err_cause <= CAUSE_NONE;
      err_src   <= '0;
    end else begin
      state_q   <= state_d;
      err       <= err_d;
      err_cause <= cause_d;
      err_src   <= src_d;
    end
  end

`ifdef ERR_MON_WDOG_EN
  // Commit-free cycle counter; saturation comes from the FAULT hold.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor (NUM_SRC=4, WDOG_CYCLES=8, CNT_W=4).
// Watchdog checks run when ERR_MON_WDOG_EN is defined; otherwise the
// watchdog-less behaviour is checked.
module tb_err_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_err;
  logic       commit;
  logic       halt;
  logic       err;
  logic [1:0] err_cause;
  logic [3:0] err_src;
  logic [3:0] wdog_cnt;

  int errors = 0;
  int checks = 0;

  err_monitor #(.NUM_SRC(4), .WDOG_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .src_err(src_err), .commit(commit), .halt(halt),
    .err(err), .err_cause(err_cause), .err_src(err_src), .wdog_cnt(wdog_cnt)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e, input logic [1:0] c,
                         input logic [3:0] s, input logic [3:0] n);
    chk({tag, ".err"},   32'(err),       32'(e));
    chk({tag, ".cause"}, 32'(err_cause), 32'(c));
    chk({tag, ".src"},   32'(err_src),   32'(s));
    chk({tag, ".cnt"},   32'(wdog_cnt),  32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1; src_err = '0; commit = 1'b0; halt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_err = '0; commit = 1'b0; halt = 1'b0;
    tick(); tick();
    chk_all("reset", 1'b0, 2'd0, 4'd0, 4'd0);
    rst = 1'b0;

`ifdef ERR_MON_WDOG_EN
    // steady commits never fault
    commit = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_all("commit_run", 1'b0, 2'd0, 4'd0, 4'd0);
    end

    // commit-free count up to timeout, then held
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_all("wdog_count", 1'b0, 2'd0, 4'd0, 4'(i));
    end
    tick();
    chk_all("wdog_timeout", 1'b1, 2'd2, 4'd0, 4'd8);
    for (int i = 0; i < 20; i++) begin
      commit = i[0]; src_err = 4'(i); halt = i[1];
      tick();
      chk_all("wdog_hold", 1'b1, 2'd2, 4'd0, 4'd8);
    end

    // commit on the timeout cycle wins
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    chk("pre_timeout.cnt", 32'(wdog_cnt), 32'd7);
    commit = 1'b1;
    tick();
    chk_all("commit_at_limit", 1'b0, 2'd0, 4'd0, 4'd0);
    commit = 1'b0;
    tick();
    chk_all("restart_count", 1'b0, 2'd0, 4'd0, 4'd1);

    // source error beats halt; only first fault recorded
    do_reset();
    src_err = 4'b0110; halt = 1'b1;
    tick();
    chk_all("src_fault", 1'b1, 2'd1, 4'b0110, 4'd0);
    src_err = 4'b0001; halt = 1'b0;
    tick();
    chk_all("src_sticky", 1'b1, 2'd1, 4'b0110, 4'd0);

    // halted: counter frozen, commit is illegal
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    halt = 1'b1; commit = 1'b1;     // commit with halt is legal
    tick();
    chk_all("halt_enter", 1'b0, 2'd0, 4'd0, 4'd3);
    commit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      halt = i[0];                  // repeated halt ignored
      tick();
    end
    chk_all("halted_wait", 1'b0, 2'd0, 4'd0, 4'd3);
    halt = 1'b0; commit = 1'b1;
    tick();
    chk_all("halt_commit", 1'b1, 2'd3, 4'd0, 4'd3);

    // reset out of a watchdog fault, then normal running
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk_all("wdog_fault2", 1'b1, 2'd2, 4'd0, 4'd8);
    do_reset();
    chk_all("fault_reset", 1'b0, 2'd0, 4'd0, 4'd0);
    commit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_all("post_reset_run", 1'b0, 2'd0, 4'd0, 4'd0);

    // source error while halted beats a commit
    do_reset();
    halt = 1'b1;
    tick();
    halt = 1'b0; src_err = 4'b1000; commit = 1'b1;
    tick();
    chk_all("halted_src", 1'b1, 2'd1, 4'b1000, 4'd0);

    // reset wins over simultaneous error
    rst = 1'b1; src_err = 4'b1111;
    tick();
    chk_all("rst_override", 1'b0, 2'd0, 4'd0, 4'd0);
    rst = 1'b0; src_err = '0; commit = 1'b0;
`else
    // no watchdog: long commit-free stretch is fine
    for (int i = 0; i < 100; i++) tick();
    chk_all("nowdog_idle", 1'b0, 2'd0, 4'd0, 4'd0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_all("nowdog_halted", 1'b0, 2'd0, 4'd0, 4'd0);
    commit = 1'b1;
    tick();
    chk_all("nowdog_halt_commit", 1'b1, 2'd3, 4'd0, 4'd0);
    src_err = 4'b0101;
    tick();
    chk_all("nowdog_sticky", 1'b1, 2'd3, 4'd0, 4'd0);
    do_reset();
    chk_all("nowdog_reset", 1'b0, 2'd0, 4'd0, 4'd0);
    src_err = 4'b0010;
    tick();
    chk_all("nowdog_src", 1'b1, 2'd1, 4'b0010, 4'd0);
    src_err = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
